ysyx_23060240_axi_sram: RTL and testbench
=========================================

# ysyx_23060240_axi_sram

AXI4-Lite slave memory that answers the IFU/LSU read and write channels. It is the responder end of the fetch/load-store bus: it accepts address and data handshakes, waits a programmable or pseudo-random latency, then returns read data or a write response. It lets the core's handshake logic be exercised under non-zero, variable memory latency.

## Interface
- BASE_ADDR, 32'h8000_0000, first byte address mapped to word 0
- DEPTH_LOG2, 12, memory holds 2^DEPTH_LOG2 32-bit words
- RD_LAT, 2, read latency in cycles after the AR handshake (0 allowed)
- WR_LAT, 2, write latency in cycles after both AW and W are captured (0 allowed)

- clk  in  1  sole clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready

## Operation
- Read FSM: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE. arready=1 only in R_IDLE. On arvalid&&arready: latch araddr, load counter with latency. R_WAIT decrements; at 0 sample memory, drive rdata/rresp, enter R_RESP. Latency 0 skips R_WAIT (R_IDLE -> R_RESP directly). R_RESP holds rvalid=1 and rdata/rresp stable until rvalid&&rready, then R_IDLE.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP -> W_IDLE. In W_IDLE awready=!aw_captured, wready=!w_captured; AW and W accepted independently in either order or same cycle. When both captured, load counter, enter W_WAIT. At 0 commit write (per-byte wstrb), drive bresp, enter W_RESP; bvalid held until bvalid&&bready.
- Decode: offset=addr-BASE_ADDR; in range if offset < 4*2^DEPTH_LOG2; word index=offset[DEPTH_LOG2+1:2]; addr[1:0] ignored. Out of range: resp 2'b10, rdata=32'h0, no memory update.
- Read and write FSMs fully independent; both may be active at once. Same-cycle read sample and write commit to same word: read returns pre-write data.
- Memory contents not cleared by reset.

## Timing
- Reset: arready=0, rvalid=0, rdata=0, rresp=0, awready=0, wready=0, bvalid=0, bresp=0; FSMs to IDLE, capture flags and counters cleared. Ready outputs go 1 the first cycle after rst deasserts.
- Reset mid-transaction aborts it; pending write not committed; no response issued.
- Read: AR handshake in cycle T -> rvalid=1 in cycle T+1+lat. Next AR accepted the cycle after the R handshake.
- Write: last of AW/W handshakes in cycle T -> bvalid=1 in cycle T+1+lat; memory updated at same edge.
- Responses are registered outputs; no combinational path from any input to any output.

## Configuration
- AXI_SRAM_RAND_DELAY_EN defined: latency per transaction = lfsr[2:0] (0..7), sampled at the starting handshake; 8-bit Fibonacci LFSR taps 8,6,5,4, seed 8'hA5 on reset, steps every cycle; RD_LAT/WR_LAT ignored. Read and write share the LFSR.
- Undefined: fixed RD_LAT/WR_LAT, no LFSR logic.

## Test plan
- AW 0x8000_0010 and W 32'hDEAD_BEEF, wstrb 4'hF same cycle T -> bvalid at T+3 (WR_LAT=2), bresp 00; then read 0x8000_0010 -> rdata 32'hDEAD_BEEF, rvalid 3 cycles after AR handshake.
- W before AW by 4 cycles, wstrb 4'b0011, data 32'h1234_5678 over 32'hDEAD_BEEF -> read returns 32'hDEAD_5678.
- Read 0x7FFF_FFFC and 0x8000_4000 -> rresp 10, rdata 0; write to 0x8000_4000 -> bresp 10, word 0 unchanged.
- rready held low 5 cycles in R_RESP -> rvalid and rdata stable; arready stays 0 until handshake.
- rst asserted during W_WAIT -> bvalid never rises, target word unchanged, all outputs at reset values next cycle.
- With AXI_SRAM_RAND_DELAY_EN: 100 back-to-back reads -> latencies span 0..7, data always correct.

Source files
------------

// File: rtl/ysyx_23060240_axi_sram.sv
// AXI4-Lite slave SRAM with independent read/write FSMs and a fixed or pseudo-random response latency.
// Define AXI_SRAM_RAND_DELAY_EN to draw per-transaction latency (0..7) from a shared 8-bit LFSR.
module ysyx_23060240_axi_sram #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < SPAN;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[DEPTH_LOG2+1:2];
  endfunction

  logic [31:0] mem [1 << DEPTH_LOG2];

  logic [7:0] rd_lat, wr_lat;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign rd_lat = {5'd0, lfsr_q[2:0]};
  assign wr_lat = {5'd0, lfsr_q[2:0]};
`else
  assign rd_lat = 8'(RD_LAT);
  assign wr_lat = 8'(WR_LAT);
`endif

  r_state_e    r_state_q, r_state_d;
  logic [7:0]  r_cnt_q, r_cnt_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rvalid_q, rvalid_d, arready_q, arready_d;
  logic        r_sample;
  logic [31:0] r_sample_addr;

  always_comb begin
    r_state_d     = r_state_q;
    r_cnt_d       = r_cnt_q;
    r_addr_d      = r_addr_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    rvalid_d      = rvalid_q;
    r_sample      = 1'b0;
    r_sample_addr = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_addr_d = araddr;
          if (rd_lat == 8'd0) begin
            r_sample      = 1'b1;
            r_sample_addr = araddr;
          end else begin
            r_cnt_d   = rd_lat - 8'd1;
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 8'd0) r_sample = 1'b1;
        else                 r_cnt_d  = r_cnt_q - 8'd1;
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Memory is read before any same-edge write commit, so a colliding read sees old data.
    if (r_sample) begin
      r_state_d = R_RESP;
      rvalid_d  = 1'b1;
      if (in_range(r_sample_addr)) begin
        rdata_d = mem[word_idx(r_sample_addr)];
        rresp_d = 2'b00;
      end else begin
        rdata_d = 32'h0;
        rresp_d = 2'b10;
      end
    end
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 8'd0;
      r_addr_q  <= 32'h0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  w_state_e    w_state_q, w_state_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic [31:0] w_addr_q, w_addr_d, w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        bvalid_q, bvalid_d, awready_q, awready_d, wready_q, wready_d;
  logic        w_commit, mem_we;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    w_commit  = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_addr_d = awaddr;
          aw_cap_d = 1'b1;
        end
        if (wvalid && wready_q) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          w_cap_d  = 1'b1;
        end
        if (aw_cap_d && w_cap_d) begin
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
          if (wr_lat == 8'd0) begin
            w_commit = 1'b1;
          end else begin
            w_cnt_d   = wr_lat - 8'd1;
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 8'd0) w_commit = 1'b1;
        else                 w_cnt_d  = w_cnt_q - 8'd1;
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_commit) begin
      w_state_d = W_RESP;
      bvalid_d  = 1'b1;
      mem_we    = in_range(w_addr_d);
      bresp_d   = in_range(w_addr_d) ? 2'b00 : 2'b10;
    end
    awready_d = (w_state_d == W_IDLE) && !aw_cap_d;
    wready_d  = (w_state_d == W_IDLE) && !w_cap_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 8'd0;
      w_addr_q  <= 32'h0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      bresp_q   <= 2'b00;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  // Storage has no reset; a reset landing on the commit edge must drop the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_d[b]) mem[word_idx(w_addr_d)][8*b +: 8] <= w_data_d[8*b +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_ysyx_23060240_axi_sram.sv
// Self-checking bench for ysyx_23060240_axi_sram: directed scenarios plus randomized traffic
// checked against an array-based memory model and the documented latency rule.
module tb_ysyx_23060240_axi_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] modelMem [4096];

  ysyx_23060240_axi_sram dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  function automatic bit inRange(input logic [31:0] a);
    return (a - BASE) < 32'h4000;
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 4095;
  endfunction

  function automatic logic [1:0] expResp(input logic [31:0] a);
    return inRange(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] expData(input logic [31:0] a);
    return inRange(a) ? modelMem[wordOf(a)] : 32'h0;
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (inRange(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) modelMem[wordOf(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkLat(input string tag, input int lat);
`ifdef AXI_SRAM_RAND_DELAY_EN
    checkOutput(tag, 64'(lat <= 7), 64'd1);
`else
    checkOutput(tag, 64'(lat), 64'(LAT));
`endif
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, {24'd0, arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp}, 64'd0);
  endtask

  // Drives one AR/R exchange; rready is withheld for 'hold' cycles once rvalid rises.
  task automatic applyRead(input logic [31:0] addr, input int hold, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit stable);
    bit hs;
    int cyc;
    logic [31:0] first;
    hs = 0; cyc = 0; lat = 99; stable = 1; data = 32'hx; resp = 2'bx;
    araddr = addr; arvalid = 1'b1;
    while (!hs && cyc < 50) begin
      hs = arready;
      @(negedge clk);
      cyc++;
    end
    arvalid = 1'b0;
    if (hs) begin
      for (int n = 0; n < 20; n++) begin
        if (rvalid === 1'b1) begin lat = n; break; end
        @(negedge clk);
      end
    end
    if (lat != 99) begin
      first = rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!(rvalid === 1'b1 && arready === 1'b0 && rdata === first)) stable = 0;
      end
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  // Presents W first and AW 'gap' cycles later (gap 0 = same cycle).
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int gap, input int hold, output logic [1:0] resp, output int lat,
                               output bit stable);
    bit awDone, wDone, awHs, wHs;
    int cyc;
    awDone = 0; wDone = 0; cyc = 0; lat = 99; resp = 2'bx; stable = 1;
    awaddr = addr; wdata = data; wstrb = strb;
    wvalid = 1'b1; awvalid = (gap == 0);
    while (!(awDone && wDone) && cyc < 50) begin
      awHs = awvalid && awready;
      wHs  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (awHs) begin awvalid = 1'b0; awDone = 1; end
      if (wHs)  begin wvalid  = 1'b0; wDone  = 1; end
      if (!awDone && !awvalid && cyc >= gap) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (awDone && wDone) begin
      for (int n = 0; n < 20; n++) begin
        if (bvalid === 1'b1) begin lat = n; break; end
        @(negedge clk);
      end
    end
    if (lat != 99) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (bvalid !== 1'b1) stable = 0;
      end
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d, a;
    logic [1:0]  r;
    logic [3:0]  s;
    int          lat;
    bit          st, sawB;

    rst = 1'b1;
    araddr = 0; arvalid = 0; rready = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {61'd0, arready, awready, wready}, 64'd7);

    // Full-word write then read back.
    applyStimulus(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r, lat, st);
    modelWrite(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    checkOutput("wr_same_cycle_bresp", 64'(r), 64'd0);
    checkLat("wr_same_cycle_lat", lat);
    applyRead(32'h8000_0010, 0, d, r, lat, st);
    checkOutput("rd_deadbeef_data", 64'(d), 64'hDEAD_BEEF);
    checkOutput("rd_deadbeef_resp", 64'(r), 64'd0);
    checkLat("rd_deadbeef_lat", lat);

    // W leads AW by four cycles, partial strobe.
    applyStimulus(32'h8000_0010, 32'h1234_5678, 4'b0011, 4, 0, r, lat, st);
    modelWrite(32'h8000_0010, 32'h1234_5678, 4'b0011);
    checkOutput("wr_w_first_bresp", 64'(r), 64'd0);
    checkLat("wr_w_first_lat", lat);
    applyRead(32'h8000_0013, 0, d, r, lat, st);
    checkOutput("rd_partial_data", 64'(d), 64'hDEAD_5678);

    // Out-of-range on both sides of the window.
    applyStimulus(32'h8000_0000, 32'h1111_2222, 4'hF, 0, 0, r, lat, st);
    modelWrite(32'h8000_0000, 32'h1111_2222, 4'hF);
    applyRead(32'h7FFF_FFFC, 0, d, r, lat, st);
    checkOutput("rd_below_base", {30'd0, r, d}, {30'd0, 2'b10, 32'h0});
    applyRead(32'h8000_4000, 0, d, r, lat, st);
    checkOutput("rd_above_top", {30'd0, r, d}, {30'd0, 2'b10, 32'h0});
    applyStimulus(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 1, 0, r, lat, st);
    checkOutput("wr_above_top_bresp", 64'(r), 64'd2);
    applyRead(32'h8000_0000, 0, d, r, lat, st);
    checkOutput("word0_unchanged", 64'(d), 64'(expData(32'h8000_0000)));

    // Backpressure on R and B channels.
    applyRead(32'h8000_0010, 5, d, r, lat, st);
    checkOutput("rready_low_stable", 64'(st), 64'd1);
    checkOutput("rready_low_data", 64'(d), 64'hDEAD_5678);
    applyStimulus(32'h8000_0024, 32'hA5A5_5A5A, 4'hF, 2, 4, r, lat, st);
    modelWrite(32'h8000_0024, 32'hA5A5_5A5A, 4'hF);
    checkOutput("bready_low_stable", 64'(st), 64'd1);

`ifndef AXI_SRAM_RAND_DELAY_EN
    // Reset while the write is waiting must drop it.
    applyStimulus(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 0, 0, r, lat, st);
    modelWrite(32'h8000_0020, 32'hCAFE_F00D, 4'hF);
    awaddr = 32'h8000_0020; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset_in_wwait");
    rst = 1'b0;
    sawB = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b0) sawB = 1;
    end
    checkOutput("reset_no_bvalid", 64'(sawB), 64'd0);
    applyRead(32'h8000_0020, 0, d, r, lat, st);
    checkOutput("reset_word_unchanged", 64'(d), 64'hCAFE_F00D);
`endif

    // Randomized traffic over a small initialized window plus stray out-of-range addresses.
    for (int k = 0; k < 16; k++) begin
      a = 32'h8000_0100 + 32'(k * 4);
      d = $urandom;
      applyStimulus(a, d, 4'hF, 0, 0, r, lat, st);
      modelWrite(a, d, 4'hF);
      checkOutput("init_bresp", 64'(r), 64'd0);
    end
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'h8000_4000 + 32'($urandom_range(0, 1023))
                                        : 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
      else
        a = 32'h8000_0100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        applyStimulus(a, d, s, $urandom_range(0, 3), $urandom_range(0, 2), r, lat, st);
        checkOutput("rnd_bresp", 64'(r), 64'(expResp(a)));
        checkLat("rnd_wr_lat", lat);
        modelWrite(a, d, s);
      end else begin
        applyRead(a, $urandom_range(0, 3), d, r, lat, st);
        checkOutput("rnd_rdata", {30'd0, r, d}, {30'd0, expResp(a), expData(a)});
        checkLat("rnd_rd_lat", lat);
        checkOutput("rnd_r_stable", 64'(st), 64'd1);
      end
    end

`ifdef AXI_SRAM_RAND_DELAY_EN
    begin
      logic [7:0] seen;
      seen = 8'h0;
      for (int k = 0; k < 100; k++) begin
        a = 32'h8000_0100 + 32'($urandom_range(0, 15) * 4);
        applyRead(a, 0, d, r, lat, st);
        checkOutput("rand_lat_rdata", 64'(d), 64'(expData(a)));
        if (lat <= 7) seen[lat] = 1'b1;
      end
      checkOutput("rand_lat_span", 64'(seen), 64'hFF);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
